// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the system-ID checker (master) and the system-ID slave.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_checker.sv
// System-ID checker: reads the ID and build timestamp words from the system-ID
// slave and produces a sticky verdict used to gate acquisition start-up.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd781556648,
  parameter logic [31:0] EXPECTED_TS    = 32'd1309904185,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout,
  output logic [31:0]            id_word,
  output logic [31:0]            ts_word
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LAT_W    = 2;
  // Latency counter counts down to zero; zero marks the capture edge.
  localparam int unsigned LAT_LOAD = (READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } state_e;

  state_e              state_q,    state_d;
  logic                auto_q,     auto_d;
  logic [LAT_W-1:0]    lat_q,      lat_d;
  logic [CNT_W-1:0]    to_cnt_q,   to_cnt_d;
  logic                read_q,     read_d;
  logic                address_q,  address_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                pass_q,     pass_d;
  logic                id_ok_q,    id_ok_d;
  logic                ts_ok_q,    ts_ok_d;
  logic                timeout_q,  timeout_d;
  logic [DATA_W-1:0]   id_word_q,  id_word_d;
  logic [DATA_W-1:0]   ts_word_q,  ts_word_d;
  logic                launch;
  logic                to_expired;

  assign to_expired = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and next-output computation for the read/compare sequence.
  always_comb begin
    state_d    = state_q;
    auto_d     = 1'b0;
    lat_d      = lat_q;
    to_cnt_d   = to_cnt_q;
    read_d     = read_q;
    address_d  = address_q;
    done_d     = done_q;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_word_d  = id_word_q;
    ts_word_d  = ts_word_q;
    launch     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start || auto_q) begin
          launch = 1'b1;
        end
      end

      RD_ID: begin
        if (!avm.avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            id_word_d = avm.avm_readdata;
            state_d   = RD_TS;
            address_d = 1'b1;
            to_cnt_d  = '0;
          end else begin
            state_d = LAT_ID;
            read_d  = 1'b0;
            lat_d   = LAT_W'(LAT_LOAD);
          end
        end else if (to_expired) begin
          // Nothing captured yet, so neither word can be vouched for.
          state_d   = DONE;
          read_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end

      LAT_ID: begin
        if (lat_q == '0) begin
          id_word_d = avm.avm_readdata;
          state_d   = RD_TS;
          read_d    = 1'b1;
          address_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      RD_TS: begin
        if (!avm.avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            ts_word_d = avm.avm_readdata;
            state_d   = CHECK;
            read_d    = 1'b0;
          end else begin
            state_d = LAT_TS;
            read_d  = 1'b0;
            lat_d   = LAT_W'(LAT_LOAD);
          end
        end else if (to_expired) begin
          // ID word is already captured; report its match status only.
          state_d   = DONE;
          read_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          id_ok_d   = (id_word_q == EXPECTED_ID);
          ts_ok_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end

      LAT_TS: begin
        if (lat_q == '0) begin
          ts_word_d = avm.avm_readdata;
          state_d   = CHECK;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      CHECK: begin
        id_ok_d = (id_word_q == EXPECTED_ID);
        ts_ok_d = (ts_word_q == EXPECTED_TS);
        pass_d  = (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS);
        done_d  = 1'b1;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
      end
    endcase

    // A new check wipes the previous verdict and captured words.
    if (launch) begin
      state_d   = RD_ID;
      read_d    = 1'b1;
      address_d = 1'b0;
      to_cnt_d  = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
      id_word_d = '0;
      ts_word_d = '0;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      auto_q    <= AUTO_START;
      lat_q     <= '0;
      to_cnt_q  <= '0;
      read_q    <= 1'b0;
      address_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_word_q <= '0;
      ts_word_q <= '0;
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      lat_q     <= lat_d;
      to_cnt_q  <= to_cnt_d;
      read_q    <= read_d;
      address_q <= address_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign id_word         = id_word_q;
  assign ts_word         = ts_word_q;

endmodule
